// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : shares a single-ported data memory between the CPU MEM stage
//                (port 0, priority) and the debug/loader port (port 1).
// Revision     : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

  state_t        r_state,     w_state_nx;
  logic [AW-1:0] r_mem_addr,  w_mem_addr_nx;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nx;
  logic          r_mem_read,  w_mem_read_nx;
  logic          r_mem_write, w_mem_write_nx;
  logic [DW-1:0] r_p0_rdata,  w_p0_rdata_nx;
  logic [DW-1:0] r_p1_rdata,  w_p1_rdata_nx;
  logic          r_p0_ack,    w_p0_ack_nx;
  logic          r_p1_ack,    w_p1_ack_nx;
  logic          r_busy,      w_busy_nx;
  logic          r_owner,     w_owner_nx;
  logic [3:0]    r_starve,    w_starve_nx;

  logic          w_starved;
  logic          w_take1;
  logic          w_any_req;

  assign w_starved = (r_starve == c_STARVE_LIMIT);
  // Port 1 wins when alone, or when port 0 has starved it for STARVE_LIMIT grants.
  assign w_take1   = p1_req & (~p0_req | w_starved);
  assign w_any_req = p0_req | p1_req;

  always_comb begin
    w_state_nx     = r_state;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = r_mem_wdata;
    w_mem_read_nx  = 1'b0;
    w_mem_write_nx = 1'b0;
    w_p0_rdata_nx  = r_p0_rdata;
    w_p1_rdata_nx  = r_p1_rdata;
    w_p0_ack_nx    = 1'b0;
    w_p1_ack_nx    = 1'b0;
    w_busy_nx      = r_busy;
    w_owner_nx     = r_owner;
    w_starve_nx    = r_starve;

    case (r_state)
      S_IDLE: begin
        if (!p1_req) begin
          w_starve_nx = 4'd0;
        end
        if (w_any_req) begin
          w_owner_nx     = w_take1;
          w_mem_addr_nx  = w_take1 ? p1_addr  : p0_addr;
          w_mem_wdata_nx = w_take1 ? p1_wdata : p0_wdata;
          w_mem_read_nx  = w_take1 ? ~p1_we   : ~p0_we;
          w_mem_write_nx = w_take1 ? p1_we    : p0_we;
          w_busy_nx      = 1'b1;
          w_state_nx     = S_CMD;
          if (w_take1) begin
            w_starve_nx = 4'd0;
          end else if (p1_req && !w_starved) begin
            w_starve_nx = r_starve + 4'd1;
          end
        end
      end
      S_CMD: begin
        if (r_mem_read) begin
          if (r_owner) begin
            w_p1_rdata_nx = mem_rdata;
          end else begin
            w_p0_rdata_nx = mem_rdata;
          end
        end
        w_p0_ack_nx = ~r_owner;
        w_p1_ack_nx = r_owner;
        w_state_nx  = S_RESP;
      end
      S_RESP: begin
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_p0_ack    <= 1'b0;
      r_p1_ack    <= 1'b0;
      r_busy      <= 1'b0;
      r_owner     <= 1'b0;
      r_starve    <= 4'd0;
    end else begin
      r_state     <= w_state_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      r_mem_read  <= w_mem_read_nx;
      r_mem_write <= w_mem_write_nx;
      r_p0_rdata  <= w_p0_rdata_nx;
      r_p1_rdata  <= w_p1_rdata_nx;
      r_p0_ack    <= w_p0_ack_nx;
      r_p1_ack    <= w_p1_ack_nx;
      r_busy      <= w_busy_nx;
      r_owner     <= w_owner_nx;
      r_starve    <= w_starve_nx;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign p0_ack    = r_p0_ack;
  assign p1_ack    = r_p1_ack;
  assign busy      = r_busy;
  assign owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed scenarios plus randomized traffic for dmem_arbiter,
//                   checked every cycle against a transaction-level model.
// Revision        : 1.0
// ============================================================================
module tb_dmem_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy, owner;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  function automatic logic [15:0] init_val(input logic [5:0] a);
    return (a == 6'd10) ? 16'h00FF : {2'b00, a, 2'b00, a};
  endfunction

  // Memory seen by the DUT (64 words, aliased on the low address bits).
  logic [15:0] env_mem [64];
  logic        env_wr  [64] = '{default: 1'b0};
  assign mem_rdata = mem_read ? (env_wr[mem_addr[5:0]] ? env_mem[mem_addr[5:0]]
                                                       : init_val(mem_addr[5:0]))
                              : 16'hA5A5;
  always @(posedge clk) begin
    if (mem_write) begin
      env_mem[mem_addr[5:0]] <= mem_wdata;
      env_wr[mem_addr[5:0]]  <= 1'b1;
    end
  end

  // Transaction-level model: ph = cycles of the current access still to run.
  int          ph;
  int          m_cnt;
  bit          m_owner, m_we, take1;
  logic [15:0] m_addr, m_wdata;
  logic [15:0] m_rd [2];
  logic [15:0] model_mem [64];
  logic        model_wr  [64] = '{default: 1'b0};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph = 0; m_cnt = 0; m_owner = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_rd[0] = 0; m_rd[1] = 0;
    end else if (ph == 0) begin
      if (!p1_req) m_cnt = 0;
      if (p0_req || p1_req) begin
        take1 = p1_req && (!p0_req || m_cnt == LIM);
        if (take1) m_cnt = 0;
        else if (p1_req) m_cnt = (m_cnt + 1 > LIM) ? LIM : m_cnt + 1;
        m_owner = take1;
        m_we    = take1 ? p1_we    : p0_we;
        m_addr  = take1 ? p1_addr  : p0_addr;
        m_wdata = take1 ? p1_wdata : p0_wdata;
        ph = 2;
      end
    end else if (ph == 2) begin
      if (m_we) begin
        model_mem[m_addr[5:0]] = m_wdata;
        model_wr[m_addr[5:0]]  = 1'b1;
      end else begin
        m_rd[m_owner] = model_wr[m_addr[5:0]] ? model_mem[m_addr[5:0]]
                                              : init_val(m_addr[5:0]);
      end
      ph = 1;
    end else begin
      ph = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy",      32'(busy),      32'(ph != 0));
    chk("mem_read",  32'(mem_read),  32'(ph == 2 && !m_we));
    chk("mem_write", 32'(mem_write), 32'(ph == 2 && m_we));
    chk("mem_addr",  32'(mem_addr),  32'(m_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("p0_ack",    32'(p0_ack),    32'(ph == 1 && !m_owner));
    chk("p1_ack",    32'(p1_ack),    32'(ph == 1 && m_owner));
    chk("p0_rdata",  32'(p0_rdata),  32'(m_rd[0]));
    chk("p1_rdata",  32'(p1_rdata),  32'(m_rd[1]));
    chk("owner",     32'(owner),     32'(m_owner));
  end

  task automatic set_port(input bit p, input bit req, input bit we,
                          input logic [15:0] a, input logic [15:0] d);
    if (p) begin p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; end
    else   begin p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; end
  endtask

  task automatic run_access(input bit p, input bit we, input logic [15:0] a,
                            input logic [15:0] d, output logic [15:0] c_addr,
                            output logic [15:0] c_wdata, output bit c_wr, output int lat);
    set_port(p, 1'b1, we, a, d);
    lat = 0; c_addr = 0; c_wdata = 0; c_wr = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_read || mem_write) begin
        c_addr = mem_addr; c_wdata = mem_wdata; c_wr = mem_write;
      end
    end while (!(p ? p1_ack : p0_ack) && lat < 20);
    chk("ack_timeout", 32'(lat >= 20), 32'd0);
    if (p) p1_req = 1'b0; else p0_req = 1'b0;
  endtask

  task automatic drive_port(input bit p);
    bit req, ack;
    req = p ? p1_req : p0_req;
    ack = p ? p1_ack : p0_ack;
    if (req && ack) begin
      if (p) p1_req = 1'b0; else p0_req = 1'b0;
    end else if (req && $urandom_range(0, 39) == 0) begin
      if (p) p1_req = 1'b0; else p0_req = 1'b0;
    end else if (!req && $urandom_range(0, 2) == 0) begin
      set_port(p, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
    end
  endtask

  logic [15:0] ca, cw;
  bit          cwr;
  int          lat, cnt_a, cnt_b, g, cyc, both;
  logic [9:0]  seq;

  initial begin
    reset = 1'b0;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    // Reset in the middle of a port-0 write command.
    @(negedge clk); set_port(0, 1, 1, 16'h0008, 16'hBEEF);
    @(negedge clk);
    chk("t1_write_in_cmd", 32'(mem_write), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t1_rst_mem_write", 32'(mem_write), 32'd0);
    chk("t1_rst_busy",      32'(busy),      32'd0);
    chk("t1_rst_addr",      32'(mem_addr),  32'd0);
    chk("t1_rst_wdata",     32'(mem_wdata), 32'd0);
    p0_req = 1'b0;
    @(negedge clk); #2 reset = 1'b1;
    cnt_a = 0; cnt_b = 0;
    repeat (5) begin
      @(negedge clk);
      if (p0_ack) cnt_a++;
      if (busy)   cnt_b++;
    end
    chk("t1_no_ack",  32'(cnt_a), 32'd0);
    chk("t1_no_busy", 32'(cnt_b), 32'd0);

    // Port-0 read of 0x000A; memory holds 0x00FF there.
    @(negedge clk); set_port(0, 1, 0, 16'h000A, 16'h0);
    @(negedge clk);
    chk("t2_read_strobe", 32'(mem_read), 32'd1);
    chk("t2_addr",        32'(mem_addr), 32'h000A);
    @(negedge clk);
    chk("t2_ack",    32'(p0_ack),   32'd1);
    chk("t2_rdata",  32'(p0_rdata), 32'h00FF);
    chk("t2_p1_rd",  32'(p1_rdata), 32'h0);
    chk("t2_model",  32'(m_rd[0]),  32'h00FF);
    p0_req = 1'b0;
    @(negedge clk);
    chk("t2_idle", 32'({busy, p0_ack}), 32'd0);

    // Port-1 write then read back.
    run_access(1, 1, 16'h0020, 16'h1234, ca, cw, cwr, lat);
    chk("t3_w_addr",  32'(ca),  32'h0020);
    chk("t3_w_wdata", 32'(cw),  32'h1234);
    chk("t3_w_we",    32'(cwr), 32'd1);
    chk("t3_w_lat",   32'(lat), 32'd2);
    @(negedge clk);
    run_access(1, 0, 16'h0020, 16'h0, ca, cw, cwr, lat);
    chk("t3_r_rdata", 32'(p1_rdata), 32'h1234);
    chk("t3_r_ack",   32'(p1_ack),   32'd1);
    chk("t3_p0_keep", 32'(p0_rdata), 32'h00FF);
    @(negedge clk);

    // Both ports requesting continuously: starvation guard.
    set_port(0, 1, 0, 16'h0001, 16'h0);
    set_port(1, 1, 0, 16'h0002, 16'h0);
    g = 0; cyc = 0; both = 0; seq = '0;
    while (g < 10 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (mem_read && mem_write) both++;
      if (mem_read || mem_write) begin seq[g] = owner; g++; end
    end
    chk("t4_grants", 32'(g),    32'd10);
    chk("t4_seq",    32'(seq),  32'h210);
    chk("t4_both",   32'(both), 32'd0);
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (4) @(negedge clk);

    // Port-0 request arriving during port-1 RESP.
    set_port(1, 1, 1, 16'h0003, 16'h0005);
    cyc = 0;
    while (!p1_ack && cyc < 10) begin @(negedge clk); cyc++; end
    chk("t5_p1_ack_seen", 32'(p1_ack), 32'd1);
    p1_req = 1'b0;
    set_port(0, 1, 0, 16'h0020, 16'h0);
    @(negedge clk);
    chk("t5_wait_idle", 32'({busy, p0_ack, p1_ack}), 32'd0);
    @(negedge clk);
    chk("t5_grant_p0", 32'({mem_read, owner}), 32'b10);
    @(negedge clk);
    chk("t5_acks",  32'({p0_ack, p1_ack}), 32'b10);
    chk("t5_rdata", 32'(p0_rdata), 32'h1234);
    p0_req = 1'b0;
    @(negedge clk);

    // Port 0 drops req right after its grant.
    set_port(0, 1, 1, 16'h0030, 16'h7777);
    @(negedge clk);
    chk("t6_cmd", 32'(mem_write), 32'd1);
    p0_req = 1'b0;
    cnt_a = 0; cnt_b = 0;
    repeat (6) begin
      @(negedge clk);
      if (p0_ack) cnt_a++;
      if (busy)   cnt_b++;
    end
    chk("t6_one_ack",  32'(cnt_a), 32'd1);
    chk("t6_no_regrant", 32'(cnt_b), 32'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
      end else begin
        drive_port(0);
        drive_port(1);
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-ported 16-bit data memory between two requesters.
- Port 0 is the CPU MEM stage; port 1 is the debug/loader port.
- Fixed priority to port 0, with a starvation guard that forces a grant to port 1.
- Produces the memory's read/write strobes, address and write data, and returns read data with a one-cycle ack per transaction.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- STARVE_LIMIT, 4, consecutive port-0 grants with p1_req high before port 1 is forced; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- p0_req  input  1  port 0 request; held until p0_ack.
- p0_we  input  1  port 0 access type: 1 = write, 0 = read.
- p0_addr  input  AW  port 0 word address.
- p0_wdata  input  DW  port 0 write data.
- p0_ack  output  1  one-cycle completion pulse.
- p0_rdata  output  DW  port 0 read data; valid with p0_ack on reads.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- mem_rdata  input  DW  memory read data; valid in the cycle mem_read is high.
- busy  output  1  high in any state other than IDLE.
- owner  output  1  port that holds the current or most recent grant.

Behaviour:
- FSM states: IDLE, CMD, RESP. State is registered and all outputs come from registers.
- Reset (reset low, asynchronous, any state, including mid-transaction):
  - state goes to IDLE.
  - mem_read, mem_write, p0_ack, p1_ack and busy go to 0.
  - mem_addr, mem_wdata, p0_rdata and p1_rdata go to 0.
  - owner and the starvation count go to 0.
  - An in-flight access is abandoned and no ack is issued.
- IDLE:
  - Sample p0_req and p1_req on each edge.
  - Neither request high: stay in IDLE.
  - Only one request high: grant that port.
  - Both requests high: grant port 0, unless the starvation count equals STARVE_LIMIT, in which case grant port 1.
  - On a grant, latch the winner's addr, wdata and we into the mem_* registers, set owner, and go to CMD.
- CMD (exactly 1 cycle):
  - mem_read = ~we or mem_write = we; exactly one is high, never both.
  - mem_addr and mem_wdata are held stable.
  - At the end of the cycle, on a read, capture mem_rdata into the owner's rdata register.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - Strobes are low.
  - The owner's ack is 1. The other port's ack is 0.
  - Go to IDLE.
- Latency and throughput:
  - A grant on edge N means strobes are high in cycle N+1 and ack is high in cycle N+2.
  - Back-to-back throughput is one access per 3 cycles.
- Requester handshake rules:
  - Requesters hold req, we, addr and wdata stable from req rising until ack.
  - A requester must drop req in the cycle after ack, otherwise the arbiter treats it as a new request.
  - Dropping req before ack has no effect: the latched command still completes and still acks.
- rdata registers:
  - Each pN_rdata changes only on a read completed by port N.
  - Writes and the other port's accesses leave it unchanged.
- Starvation counter (4 bits):
  - Increments on each port-0 grant made while p1_req is high.
  - Clears on any port-1 grant, and in any IDLE cycle with p1_req low.
  - Saturates at STARVE_LIMIT.
- Address arithmetic: none. Addresses pass through unmodified; no wrap logic is needed.
- Simultaneous new request in a CMD or RESP cycle: no effect until the next IDLE evaluation.

Test Plan:
- Reset low mid-CMD with a port-0 write to 0x0008 -> mem_write drops immediately, no p0_ack ever, all outputs 0, state IDLE; after reset high, busy stays 0.
- Port-0 read at 0x000A, memory returns 0x00FF -> mem_read high 1 cycle later, p0_ack 2 cycles after grant, p0_rdata = 0x00FF, p1_rdata unchanged at 0.
- Port-1 write 0x1234 to 0x0020, then port-1 read of 0x0020 -> mem_write with mem_addr=0x0020 and mem_wdata=0x1234; the read returns 0x1234 with p1_ack.
- Both requesters permanently high, STARVE_LIMIT=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; owner tracks it; mem_read and mem_write never high together.
- Port-0 request arriving during a port-1 RESP cycle -> waits; granted at the following IDLE; p1_ack only in its own RESP cycle.
- Port-0 requester drops req one cycle after grant -> access still completes and p0_ack still pulses once; no further grant.
